ahb_slave_mem: RTL and testbench
================================

# ahb_slave_mem

AHB-Lite responder holding a small word-addressed memory. It is the far end of the transfers issued by `ahb_master`. It accepts pipelined address and data phases, optionally inserts wait states, and returns OKAY or a two-cycle ERROR response. It serves as the bench target for master read/write tasks and as the reference slave model ahead of the APB bridge.

## Interface
- `BASE_ADDR`, 32'h8000_0000: first byte address decoded; must be 4·DEPTH aligned.
- `DEPTH`, 16: number of 32-bit words; power of two, ≥2.
- `WAIT_STATES`, 1: wait cycles per OKAY data phase, 0..15; used only with `AHB_SLAVE_WAIT_EN`.
- `hclk` in 1: clock; all state changes on the rising edge.
- `hresetn` in 1: reset; asynchronous, active-low.
- `hwrite` in 1: 1 = write, sampled in the address phase.
- `hreadyin` in 1: bus HREADY as seen by this slave.
- `htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `haddr` in 32: byte address.
- `hwdata` in 32: write data, valid in the data phase.
- `hreadyout` out 1: 0 extends the current data phase.
- `hresp` out 2: 00 OKAY, 01 ERROR.
- `hrdata` out 32: read data.

## Operation
- Accept an address phase on an edge where `hreadyin & hreadyout & htrans[1]` is true. Register the address, `hwrite`, and the in-range flag. IDLE and BUSY are never accepted and leave all state unchanged.
- In range means BASE_ADDR ≤ haddr < BASE_ADDR+4·DEPTH. Word index = haddr[log2(DEPTH)+1:2]. haddr[1:0] is ignored, so all accesses are full-word and 0x8000_0001 maps to word 0.
- State machine has five states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept in range, go to WAIT if the wait count is >0, else DATA. On accept out of range, go to ERR1.
  - WAIT: count down and go to DATA when the count reaches zero.
  - DATA: final data-phase cycle. On a new accept, loop as from IDLE; otherwise go to IDLE.
  - ERR1 → ERR2 unconditionally. ERR2 behaves like DATA for the next accept.
- Write commits `hwdata` into the memory on the edge that ends the DATA cycle.
- Read loads `hrdata` from the memory on the accepting edge and holds it stable through the data phase.
  - Forwarding: if a write is committing on the same edge to the same index, `hrdata` takes `hwdata` instead.
- Errors never modify the memory and drive `hrdata` = 0.
- Reset values: `hreadyout`=1, `hresp`=00, `hrdata`=0, state IDLE, wait counter 0, all memory words 0.
- Reset asserted mid-transfer aborts the transfer immediately, and any write not yet committed is lost.

## Timing
- Address accepted at edge N.
- Zero-wait OKAY: data phase is cycle N..N+1, with `hreadyout`=1 and `hresp`=00. A write commits at N+1, and the read value is visible after N.
- With W wait states: `hreadyout`=0 and `hresp`=00 for W cycles, then 1 for one cycle. The write commits at edge N+W+1.
- ERROR: cycle 1 has `hreadyout`=0, `hresp`=01. Cycle 2 has `hreadyout`=1, `hresp`=01. Wait states are never added to an error.
- A new accept is permitted on the last data-phase edge, giving back-to-back transfers with no bubble.
- `hresp` returns to 00 the cycle after ERR2 unless a new error is accepted.

## Configuration
- `AHB_SLAVE_WAIT_EN` defined: the wait counter is built and every OKAY data phase takes WAIT_STATES extra cycles.
- Undefined: no counter is built, the WAIT state is unreachable, and all OKAY transfers are zero-wait regardless of WAIT_STATES.

## Structure
- Package `ahb_pkg`:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP codes: OKAY, ERROR.
  - Slave state enum.
- Sub-module `ahb_slave_ram`: DEPTH×32 array with one write port, one read port, and async clear. The top level holds the FSM, decode, wait counter and forwarding.

## Test plan
- Write 32'h0000_0080 to 0x8000_0001, then read 0x8000_0000 → `hrdata`=32'h0000_0080, `hresp`=00 on every data cycle.
- NONSEQ write to 0x9000_0000 → `hreadyout` reads 0 then 1, `hresp`=01 for both cycles; a following read of word 0 is unchanged.
- Back-to-back write 0xDEAD_BEEF to 0x8000_0008, with a read of 0x8000_0008 accepted on the commit edge → read returns 0xDEAD_BEEF (forwarded).
- With `AHB_SLAVE_WAIT_EN` and WAIT_STATES=3, a read → `hreadyout` low for exactly 3 cycles, `hrdata` stable throughout; without the macro → zero-wait.
- `htrans`=00 or 01 with `hwrite`=1 and any address → no memory change, `hreadyout`=1, `hresp`=00.
- Deassert `hresetn` during the wait cycles of a write → outputs return to reset values asynchronously and the target word reads 0 afterwards.

Source files
------------

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and the slave state type used by ahb_slave_mem
// and its memory sub-module.
//   htrans_e    : HTRANS transfer-type codes
//   hresp_e     : HRESP response codes (AHB-Lite uses OKAY/ERROR only)
//   slv_state_e : data-phase state of the memory slave
//   WAIT_CNT_W  : width of the wait-state down-counter (0..15 wait states)
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no data phase in progress
    ST_WAIT = 3'd1,  // OKAY data phase, stretched (hreadyout low)
    ST_DATA = 3'd2,  // last cycle of an OKAY data phase
    ST_ERR1 = 3'd3,  // first ERROR cycle (hreadyout low)
    ST_ERR2 = 3'd4   // second ERROR cycle (hreadyout high)
  } slv_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb_slave_ram.sv
// ---------------------------------------------------------------------------
// ahb_slave_ram
// DEPTH x 32-bit storage for ahb_slave_mem: one synchronous write port, one
// combinational read port, and an asynchronous clear of every word.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low clear of the whole array
//   we_i     : write enable, commits wdata_i to waddr_i on the rising edge
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index
//   rdata_o  : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module ahb_slave_ram #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array is cleared by reset because every word must read zero
  // after hresetn; this forces flops rather than a RAM macro, which is
  // acceptable for this small bench-target memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// AHB-Lite responder backed by a small word-addressed memory. Accepts
// pipelined address/data phases, returns OKAY (optionally stretched by wait
// states) or a two-cycle ERROR for addresses outside its window.
//
// Build option: define AHB_SLAVE_WAIT_EN to build the wait counter; every
// OKAY data phase then takes WAIT_STATES extra cycles. Without it all OKAY
// transfers are zero-wait and the WAIT state is unreachable.
//
// Parameters:
//   BASE_ADDR   : first decoded byte address, aligned to 4*DEPTH
//   DEPTH       : number of 32-bit words, power of two >= 2
//   WAIT_STATES : wait cycles per OKAY data phase (0..15)
// Ports:
//   hclk      : clock
//   hresetn   : asynchronous active-low reset
//   hwrite    : 1 = write (address phase)
//   hreadyin  : bus HREADY as seen by this slave
//   htrans    : transfer type
//   haddr     : byte address
//   hwdata    : write data (data phase)
//   hreadyout : 0 stretches the current data phase
//   hresp     : 00 OKAY, 01 ERROR
//   hrdata    : read data, held stable through the data phase
// ---------------------------------------------------------------------------
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef AHB_SLAVE_WAIT_EN
  localparam int unsigned WAIT_CNT = WAIT_STATES;
`else
  localparam int unsigned WAIT_CNT = 0;
`endif

  slv_state_e  st_q, st_d;
  slv_state_e  acc_st;
  logic        wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic          accept;
  logic          in_range;
  logic          commit;
  logic          fwd;
  logic [AW-1:0] a_idx;
  logic [31:0]   ram_rdata;

  // haddr[1:0] is deliberately ignored (word accesses only) and htrans[0]
  // only distinguishes NONSEQ from SEQ, which this slave treats alike.
  logic unused_bits;
  assign unused_bits = ^{haddr[1:0], htrans[0]};

  // ---------------------------------------------------------------- decode
  assign a_idx = haddr[AW+1:2];
  // BASE_ADDR is 4*DEPTH aligned, so the window test reduces to an equality
  // on the bits above the word index; this also avoids overflow of
  // BASE_ADDR+4*DEPTH for a window at the top of the address map.
  assign in_range = (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);

  // ------------------------------------------------------ response outputs
  assign hreadyout = (st_q != ST_WAIT) && (st_q != ST_ERR1);
  assign hresp     = ((st_q == ST_ERR1) || (st_q == ST_ERR2)) ? HRESP_ERROR
                                                              : HRESP_OKAY;
  assign hrdata    = hrdata_q;

  assign accept = hreadyin & hreadyout & htrans[1];

  // A write lands on the edge that closes its DATA cycle; a read accepted on
  // that same edge to the same word must see the new data.
  assign commit = (st_q == ST_DATA) && wr_q;
  assign fwd    = commit && (idx_q == a_idx);

  // ----------------------------------------------------- wait-state counter
`ifdef AHB_SLAVE_WAIT_EN
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Loaded with W-1 so that WAIT lasts exactly W cycles before DATA.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && in_range && (WAIT_CNT != 0)) begin
      cnt_d = WAIT_CNT_W'(WAIT_CNT - 1);
    end else if ((st_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // ----------------------------------------------------------- next state
  always_comb begin
    acc_st = ST_ERR1;
    if (in_range) begin
      acc_st = (WAIT_CNT != 0) ? ST_WAIT : ST_DATA;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    st_d     = st_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    hrdata_d = hrdata_q;

    unique case (st_q)
      // IDLE, DATA and ERR2 all end with hreadyout high, so each may take a
      // new address phase on its closing edge (back-to-back, no bubble).
      ST_IDLE, ST_DATA, ST_ERR2: st_d = accept ? acc_st : ST_IDLE;
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT:                   st_d = (cnt_q == '0) ? ST_DATA : ST_WAIT;
`else
      ST_WAIT:                   st_d = ST_DATA;
`endif
      ST_ERR1:                   st_d = ST_ERR2;
      default:                   st_d = ST_IDLE;
    endcase

    if (accept) begin
      wr_d  = hwrite;
      idx_d = a_idx;
      if (!in_range) begin
        hrdata_d = '0;
      end else if (!hwrite) begin
        hrdata_d = fwd ? hwdata : ram_rdata;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st_q     <= ST_IDLE;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      hrdata_q <= '0;
    end else begin
      st_q     <= st_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      hrdata_q <= hrdata_d;
    end
  end

  // --------------------------------------------------------------- storage
  ahb_slave_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (hclk),
    .rst_ni  (hresetn),
    .we_i    (commit),
    .waddr_i (idx_q),
    .wdata_i (hwdata),
    .raddr_i (a_idx),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mem
// Directed self-checking bench for ahb_slave_mem (BASE 0x8000_0000, DEPTH 16,
// WAIT_STATES 3). Expected wait count follows AHB_SLAVE_WAIT_EN.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem;
  import ahb_pkg::*;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_W = 3;
`else
  localparam int EXP_W = 0;
`endif
  localparam int MAX_WAIT = 20;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int checks   = 0;
  int failures = 0;

  ahb_slave_mem #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH       (16),
    .WAIT_STATES (3)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hwrite    (hwrite),
    .hreadyin  (hreadyin),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the same point, well clear of the next edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hwrite = wr;
    tick();
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Runs the wait cycles (if any) and the final DATA cycle of an OKAY
  // transfer; returns hrdata as seen in the final cycle.
  task automatic data_phase(input string tag, input logic [31:0] wd,
                            output logic [31:0] rd);
    int n;
    logic [31:0] first;
    n      = 0;
    hwdata = wd;
    first  = hrdata;
    while (hreadyout !== 1'b1 && n < MAX_WAIT) begin
      check({tag, "_wresp"}, 32'(hresp), 32'(HRESP_OKAY));
      check({tag, "_stable"}, hrdata, first);
      tick();
      n++;
    end
    check({tag, "_waits"}, 32'(n), 32'(EXP_W));
    check({tag, "_resp"}, 32'(hresp), 32'(HRESP_OKAY));
    rd = hrdata;
    tick();
  endtask

  task automatic write_word(input string tag, input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] rd;
    addr_phase(a, 1'b1);
    data_phase(tag, d, rd);
  endtask

  task automatic read_word(input string tag, input logic [31:0] a,
                           output logic [31:0] rd);
    addr_phase(a, 1'b0);
    data_phase(tag, 32'h0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    hresetn  = 1'b0;
    hreadyin = 1'b1;
    htrans   = HTRANS_IDLE;
    haddr    = '0;
    hwrite   = 1'b0;
    hwdata   = '0;

    // Reset state
    #12;
    check("rst_ready", 32'(hreadyout), 32'h1);
    check("rst_resp", 32'(hresp), 32'(HRESP_OKAY));
    check("rst_rdata", hrdata, 32'h0);
    #5 hresetn = 1'b1;
    tick();

    // Unaligned write maps to word 0, read back through aligned address
    write_word("wr0", 32'h8000_0001, 32'h0000_0080);
    read_word("rd0", 32'h8000_0000, rd);
    check("rd0_data", rd, 32'h0000_0080);

    // Out-of-range write: two-cycle ERROR, memory untouched, hrdata zeroed
    addr_phase(32'h9000_0000, 1'b1);
    hwdata = 32'hFFFF_FFFF;
    check("err1_ready", 32'(hreadyout), 32'h0);
    check("err1_resp", 32'(hresp), 32'(HRESP_ERROR));
    check("err1_rdata", hrdata, 32'h0);
    tick();
    check("err2_ready", 32'(hreadyout), 32'h1);
    check("err2_resp", 32'(hresp), 32'(HRESP_ERROR));
    tick();
    check("err_end_resp", 32'(hresp), 32'(HRESP_OKAY));
    check("err_end_ready", 32'(hreadyout), 32'h1);
    read_word("rd0b", 32'h8000_0000, rd);
    check("rd0b_data", rd, 32'h0000_0080);

    // Back-to-back write then read of the same word on the commit edge
    addr_phase(32'h8000_0008, 1'b1);
    hwdata = 32'hDEAD_BEEF;
    n = 0;
    while (hreadyout !== 1'b1 && n < MAX_WAIT) begin
      tick();
      n++;
    end
    check("b2b_wr_waits", 32'(n), 32'(EXP_W));
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h8000_0008;
    hwrite = 1'b0;
    tick();
    htrans = HTRANS_IDLE;
    data_phase("b2b_rd", 32'h0, rd);
    check("b2b_fwd_data", rd, 32'hDEAD_BEEF);
    read_word("rd2", 32'h8000_0008, rd);
    check("rd2_data", rd, 32'hDEAD_BEEF);

    // IDLE, BUSY and NONSEQ-without-hreadyin must not start a transfer
    hwdata = 32'h5A5A_5A5A;
    hwrite = 1'b1;
    haddr  = 32'h8000_000C;
    htrans = HTRANS_IDLE;
    tick();
    check("idle_ready", 32'(hreadyout), 32'h1);
    check("idle_resp", 32'(hresp), 32'(HRESP_OKAY));
    haddr  = 32'h8000_0000;
    htrans = HTRANS_BUSY;
    tick();
    check("busy_ready", 32'(hreadyout), 32'h1);
    check("busy_resp", 32'(hresp), 32'(HRESP_OKAY));
    haddr    = 32'h9000_0000;
    htrans   = HTRANS_NONSEQ;
    hreadyin = 1'b0;
    tick();
    check("nordy_resp", 32'(hresp), 32'(HRESP_OKAY));
    hreadyin = 1'b1;
    htrans   = HTRANS_IDLE;
    hwrite   = 1'b0;
    tick();
    check("nordy_ready", 32'(hreadyout), 32'h1);
    read_word("rd3", 32'h8000_000C, rd);
    check("rd3_data", rd, 32'h0);
    read_word("rd0c", 32'h8000_0000, rd);
    check("rd0c_data", rd, 32'h0000_0080);

    // Leave a nonzero hrdata, then reset in the middle of a write
    read_word("rd2b", 32'h8000_0008, rd);
    check("rd2b_data", rd, 32'hDEAD_BEEF);
    addr_phase(32'h8000_0010, 1'b1);
    hwdata = 32'h1234_5678;
    check("mid_ready", 32'(hreadyout), (EXP_W == 0) ? 32'h1 : 32'h0);
    #2 hresetn = 1'b0;
    #1;
    check("arst_ready", 32'(hreadyout), 32'h1);
    check("arst_resp", 32'(hresp), 32'(HRESP_OKAY));
    check("arst_rdata", hrdata, 32'h0);
    @(posedge hclk);
    #3 hresetn = 1'b1;
    tick();
    read_word("rd4", 32'h8000_0010, rd);
    check("rd4_data", rd, 32'h0);
    read_word("rd2c", 32'h8000_0008, rd);
    check("rd2c_data", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait on the clock ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
